task_7_translation: RTL and testbench

- Board-level number-translation block for DE2-style I/O.
- Loads an 8-bit switch value into a holding register when the SET key is pressed.
- Shows the held value on red LEDs, as two hexadecimal 7-segment digits, and as two decimal 7-segment digits.
- A green LED flags that the decimal value does not fit in two digits.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_decoder.sv | 34 +++
 rtl/task_7_translation.sv | 45 ++++
 tb/tb_task_7_translation.sv | 98 +++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the number-translation block: active-low 7-segment
// glyphs (bit0=a .. bit6=g) and an 8-bit binary-to-BCD converter.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Double-dabble: before each shift, any BCD digit >= 5 gets +3 so the
  // shift carries correctly into the next decade. Exact for 0..255.
  function automatic bcd_t bin2bcd8(input logic [7:0] bin);
    logic [19:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = {sr[18:0], 1'b0};
    end
    return '{hundreds: sr[19:16], tens: sr[15:12], ones: sr[11:8]};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// 4-bit value to active-low 7-segment glyph (0-9, A, b, C, d, E, F).
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven,
    // so no latch can be inferred even if the case is later narrowed.
    seg = SEG_0;
    case (digit)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/task_7_translation.sv
// Holds an 8-bit switch value loaded by a pushbutton and displays it on LEDs,
// as two hex digits and as two decimal digits with a >=100 overflow flag.
module task_7_translation
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       key0_rst,
  input  logic       key1_set,
  input  logic [7:0] sw,
  output logic       ledg8,
  output logic [7:0] ledr,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] dec6,
  output logic [6:0] dec7
);

  logic [7:0] val_d, val_q;
  bcd_t       bcd;

  // Reset has priority over load; load is level-sensitive while the key is low.
  always_comb begin
    val_d = val_q;
    if (!key0_rst)      val_d = 8'd0;
    else if (!key1_set) val_d = sw;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs as they stood before the edge.
  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  assign bcd  = bin2bcd8(val_q);
  assign ledr = val_q;

  // A non-zero hundreds digit is exactly val >= 100.
  assign ledg8 = (bcd.hundreds != 4'd0);

  seg7_decoder u_hex4 (.digit(val_q[3:0]), .seg(hex4));
  seg7_decoder u_hex5 (.digit(val_q[7:4]), .seg(hex5));
  seg7_decoder u_dec6 (.digit(bcd.ones),   .seg(dec6));
  seg7_decoder u_dec7 (.digit(bcd.tens),   .seg(dec7));

endmodule

// File: tb/tb_task_7_translation.sv
// Self-checking bench for task_7_translation: directed boundary cases then
// random key/switch activity, compared against an arithmetic reference model.
module tb_task_7_translation;

  logic       clk = 1'b0;
  logic       key0_rst = 1'b1;
  logic       key1_set = 1'b1;
  logic [7:0] sw = 8'd0;
  logic       ledg8;
  logic [7:0] ledr;
  logic [6:0] hex4, hex5, dec6, dec7;

  int n_vec = 0;
  int n_err = 0;
  int model_val = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task_7_translation dut (
    .clk(clk), .key0_rst(key0_rst), .key1_set(key1_set), .sw(sw),
    .ledg8(ledg8), .ledr(ledr), .hex4(hex4), .hex5(hex5), .dec6(dec6), .dec7(dec7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model val %0d)", tag, got, exp, model_val);
    end
  endtask

  task automatic check_outputs();
    check("ledr",  32'(ledr),  32'(model_val));
    check("ledg8", 32'(ledg8), 32'(model_val >= 100));
    check("hex5",  32'(hex5),  32'(seg_tbl[model_val / 16]));
    check("hex4",  32'(hex4),  32'(seg_tbl[model_val % 16]));
    check("dec7",  32'(dec7),  32'(seg_tbl[(model_val / 10) % 10]));
    check("dec6",  32'(dec6),  32'(seg_tbl[model_val % 10]));
  endtask

  // Drive inputs mid-cycle, advance one edge, update the model, sample after the edge.
  task automatic step(input logic rst_n, input logic set_n, input logic [7:0] sw_v);
    @(negedge clk);
    key0_rst = rst_n;
    key1_set = set_n;
    sw       = sw_v;
    @(posedge clk);
    if (!rst_n)      model_val = 0;
    else if (!set_n) model_val = int'(sw_v);
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset for two cycles, set idle.
    step(1'b0, 1'b1, 8'd77);
    step(1'b0, 1'b1, 8'd77);
    check("rst_hex5_glyph0", 32'(hex5), 32'h40);
    check("rst_dec6_glyph0", 32'(dec6), 32'h40);

    step(1'b1, 1'b0, 8'd5);
    check("load5_hex4", 32'(hex4), 32'h12);
    step(1'b1, 1'b1, 8'd0);
    check("hold5_ledr", 32'(ledr), 32'h05);

    step(1'b1, 1'b0, 8'd154);
    check("load154_dec7", 32'(dec7), 32'h12);
    check("load154_dec6", 32'(dec6), 32'h19);
    step(1'b1, 1'b0, 8'd254);
    check("track254_ledr", 32'(ledr), 32'hFE);

    step(1'b1, 1'b0, 8'd99);
    check("b99_ledg8", 32'(ledg8), 32'd0);
    step(1'b1, 1'b0, 8'd100);
    check("b100_dec7", 32'(dec7), 32'h40);
    check("b100_ledg8", 32'(ledg8), 32'd1);
    step(1'b1, 1'b0, 8'd255);
    check("b255_hex5", 32'(hex5), 32'h0E);
    check("b255_dec6", 32'(dec6), 32'h12);

    // Reset while set held low, then loading resumes on the first released edge.
    step(1'b0, 1'b0, 8'd200);
    check("rst_over_set", 32'(ledr), 32'h00);
    step(1'b1, 1'b0, 8'd201);
    check("resume_after_rst", 32'(ledr), 32'd201);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0), ($urandom_range(1) != 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
